inst_capture: RTL

- Upstream front-end of the basys3 calculator core.
- Turns the raw step button and the 8 slide switches into a clean one-cycle instruction-valid strobe with a stable instruction word, which feed the core's inst_vld / inst_wd.
- Synchronises and debounces the button and captures the switches at the debounced press.
- Holds the issue while the core reports busy (e.g. UART SEND in progress).

---
 rtl/inst_if.sv | 20 ++
 rtl/inst_capture.sv | 125 ++++++++++++
 2 files changed

// File: rtl/inst_if.sv
// Instruction hand-off between the switch/button front-end and the calculator core.
// Issue semantics: inst_vld is a one-cycle strobe that carries inst_wd; the master only raises it
// in a cycle where core_busy was low when the issue was decided, and core_busy is the core's inverted ready.
interface inst_if;
  logic [7:0] inst_wd;
  logic       inst_vld;
  logic       core_busy;

  modport master (
    output inst_wd,
    output inst_vld,
    input  core_busy
  );

  modport slave (
    input  inst_wd,
    input  inst_vld,
    output core_busy
  );
endinterface

// File: rtl/inst_capture.sv
// Step-button front-end: synchronises and debounces btnS, latches the slide switches on a
// clean press and issues exactly one instruction per press, holding it while the core is busy.
module inst_capture #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       btn_in,
  inst_if.master     core,
  output logic       pending,
  output logic [7:0] issue_cnt,
  output logic [1:0] state_dbg,
  output logic       btn_db_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_ISSUE   = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             btn_s1;
  logic             btn_s2;
  logic             btn_db;
  logic             btn_db_d;
  logic             press_evt;
  logic [CNT_W-1:0] db_cnt;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             capture;
  logic [7:0]       inst_wd_q;
  logic             inst_vld_q;
  logic             pending_q;
  logic [7:0]       issue_cnt_q;

  // Two-flop synchroniser; the switches are sampled raw because they must be static at capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn_in;
      btn_s2 <= btn_s1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_s2 == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_MAX) begin
      btn_db <= btn_s2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db_d  <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      btn_db_d  <= btn_db;
      press_evt <= btn_db & ~btn_db_d;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (press_evt) begin
          capture   = 1'b1;
          state_nxt = core.core_busy ? S_WAIT : S_ISSUE;
        end
      end
      S_WAIT: begin
        if (!core.core_busy) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        state_nxt = S_RELEASE;
      end
      S_RELEASE: begin
        if (!btn_db) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so inst_vld and pending line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      inst_wd_q   <= 8'h00;
      inst_vld_q  <= 1'b0;
      pending_q   <= 1'b0;
      issue_cnt_q <= 8'h00;
    end else begin
      state      <= state_nxt;
      inst_vld_q <= (state_nxt == S_ISSUE);
      pending_q  <= (state_nxt == S_WAIT);
      if (capture) inst_wd_q <= sw;
      if (state_nxt == S_ISSUE) issue_cnt_q <= issue_cnt_q + 8'd1;
    end
  end

  assign core.inst_wd  = inst_wd_q;
  assign core.inst_vld = inst_vld_q;
  assign pending       = pending_q;
  assign issue_cnt     = issue_cnt_q;
  assign state_dbg     = state;
  assign btn_db_dbg    = btn_db;

endmodule
